// File: rtl/fetch_stage_if.sv
// Instruction-memory request/ack port between the fetch stage (master) and imem (slave).
interface fetch_stage_if;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;

   modport master (output imem_req, imem_addr, input imem_ack, imem_rdata);
   modport slave  (input imem_req, imem_addr, output imem_ack, imem_rdata);
endinterface

// File: rtl/fetch_stage.sv
// Fetch stage: owns the PC, runs one imem req/ack transaction per instruction and
// holds the fetched word for decode; PCSrc redirects the PC and flushes the slot.
module fetch_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          PCSrc,
   input  logic [31:0]   PCResult,
   input  logic          StallD,
   fetch_stage_if.master imem,
   output logic [31:0]   InstrD,
   output logic [31:0]   PCPlus4D,
   output logic          ValidD,
   output logic [3:0]    Rn,
   output logic [3:0]    Rd,
   output logic [3:0]    Rm
);

   typedef enum logic [1:0] {S_IDLE, S_FETCH, S_WAIT, S_DRAIN} state_t;

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic        req_q, req_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] instr_q, instr_d;
   logic [31:0] pcp4_q, pcp4_d;
   logic        valid_q, valid_d;

   logic [31:0] redir_pc;
   logic [31:0] pc_plus4;
   logic        slot_free;

   assign redir_pc  = PCResult & 32'hFFFF_FFFC;
   assign pc_plus4  = pc_q + 32'd4;
   assign slot_free = !valid_q || !StallD;

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      req_d   = req_q;
      addr_d  = addr_q;
      instr_d = instr_q;
      pcp4_d  = pcp4_q;
      valid_d = valid_q;

      // Redirect wins over stall and completion; the state case only decides
      // what happens to an in-flight request.
      if (PCSrc) begin
         pc_d    = redir_pc;
         valid_d = 1'b0;
      end

      case (state_q)
         S_IDLE: state_d = S_FETCH;
         S_FETCH: begin
            if (!PCSrc && slot_free) begin
               req_d   = 1'b1;
               addr_d  = pc_q;
               valid_d = 1'b0;
               state_d = S_WAIT;
            end
         end
         S_WAIT: begin
            if (imem.imem_ack) begin
               req_d   = 1'b0;
               state_d = S_FETCH;
               if (!PCSrc) begin
                  instr_d = imem.imem_rdata;
                  pcp4_d  = pc_plus4;
                  valid_d = 1'b1;
                  pc_d    = pc_plus4;
               end
            end else if (PCSrc) begin
               state_d = S_DRAIN;
            end
         end
         S_DRAIN: begin
            // Request must complete before the next one; its data is dropped.
            if (imem.imem_ack) begin
               req_d   = 1'b0;
               state_d = S_FETCH;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         pc_q    <= RESET_PC;
         req_q   <= 1'b0;
         addr_q  <= 32'h0;
         instr_q <= 32'h0;
         pcp4_q  <= 32'h0;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         req_q   <= req_d;
         addr_q  <= addr_d;
         instr_q <= instr_d;
         pcp4_q  <= pcp4_d;
         valid_q <= valid_d;
      end
   end

   assign imem.imem_req  = req_q;
   assign imem.imem_addr = addr_q;
   assign InstrD         = instr_q;
   assign PCPlus4D       = pcp4_q;
   assign ValidD         = valid_q;
   assign Rn             = instr_q[19:16];
   assign Rd             = instr_q[15:12];
   assign Rm             = instr_q[3:0];

endmodule
